// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared widths, channel-index sizing and per-channel state layout for clk_div_multi.
package clk_div_pkg;

    localparam int DIV_W_DEF = 32;

    // One divider channel's architectural state at the default width.
    typedef struct packed {
        logic [DIV_W_DEF-1:0] cnt;
        logic [DIV_W_DEF-1:0] d;
        logic [DIV_W_DEF-1:0] shadow;
        logic                 pending;
    } chan_state_t;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel (counter, compare, optional shadow divisor; CLK_DIV_MULTI_SHADOW_EN).
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int               DIV_W   = DIV_W_DEF,
    parameter logic [DIV_W-1:0] DEF_DIV = '0
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_we,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_clk,
    output logic             o_tick,
    output logic             o_pending
);

    logic [DIV_W-1:0] r_cnt, r_d;
    logic [DIV_W-1:0] w_inc, w_cnt_nxt, w_d_nxt, w_half;
    logic             r_clk, r_tick, w_wrap, w_tick_nxt;

    // cnt+1 == D stands in for cnt == D-1, so D-1 is never formed for D=0
    assign w_inc  = r_cnt + 1'b1;
    assign w_wrap = (r_d != '0) && (w_inc == r_d);

`ifdef CLK_DIV_MULTI_SHADOW_EN
    logic [DIV_W-1:0] r_shadow;
    logic             r_pend, w_apply;

    // a disabled channel has no wrap to wait for, so it takes the shadow at once
    assign w_apply    = r_pend && (w_wrap || r_d == '0);
    assign w_d_nxt    = w_apply ? r_shadow : r_d;
    assign w_cnt_nxt  = (w_wrap || r_d == '0) ? '0 : w_inc;
    assign w_tick_nxt = w_wrap && (w_d_nxt != '0);
    assign o_pending  = r_pend;

    // shadow capture; a write in the apply cycle re-arms pending for the next wrap
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_shadow <= '0;
            r_pend   <= 1'b0;
        end else if (i_we) begin
            r_shadow <= i_div;
            r_pend   <= 1'b1;
        end else if (w_apply) begin
            r_pend   <= 1'b0;
        end
    end
`else
    assign w_d_nxt    = i_we ? i_div : r_d;
    assign w_cnt_nxt  = (i_we || w_wrap || r_d == '0) ? '0 : w_inc;
    assign w_tick_nxt = w_wrap && !i_we;
    assign o_pending  = 1'b0;
`endif

    assign w_half = (w_d_nxt >> 1) + DIV_W'(w_d_nxt[0]);

    // counter, divisor and registered outputs derived from the next state
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_cnt  <= '0;
            r_d    <= DEF_DIV;
            r_clk  <= (DEF_DIV != '0);
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_d    <= w_d_nxt;
            r_clk  <= (w_cnt_nxt < w_half);
            r_tick <= w_tick_nxt;
        end
    end

    assign o_clk  = r_clk;
    assign o_tick = r_tick;

endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: N_CH independent clock dividers with write decode and ack (CLK_DIV_MULTI_SHADOW_EN: glitch-free update).
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter  int          N_CH    = 4,
    parameter  int          DIV_W   = DIV_W_DEF,
    parameter  int unsigned DEF_DIV = 50000000,
    localparam int          CH_W    = ch_w(N_CH)
) (
    input  logic             clki,
    input  logic             rstn,
    input  logic             wr_en,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic [DIV_W-1:0] wr_div,
    output logic             wr_ack,
    output logic [N_CH-1:0]  clk_out,
    output logic [N_CH-1:0]  tick_out,
    output logic [N_CH-1:0]  pending
);

    logic w_acc, r_ack;

    assign w_acc = wr_en && (32'(wr_ch) < N_CH);

    // acknowledge every accepted write one cycle later
    always_ff @(posedge clki or negedge rstn) begin
        if (!rstn) r_ack <= 1'b0;
        else       r_ack <= w_acc;
    end

    assign wr_ack = r_ack;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        clk_div_chan #(
            .DIV_W  (DIV_W),
            .DEF_DIV(DIV_W'(DEF_DIV))
        ) u_chan (
            .i_clk    (clki),
            .i_rstn   (rstn),
            .i_we     (w_acc && (32'(wr_ch) == i)),
            .i_div    (wr_div),
            .o_clk    (clk_out[i]),
            .o_tick   (tick_out[i]),
            .o_pending(pending[i])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: directed self-checking bench for clk_div_multi (expectations follow CLK_DIV_MULTI_SHADOW_EN).
module tb_clk_div_multi;

    localparam int N_CH    = 3;
    localparam int DIV_W   = 16;
    localparam int DEF_DIV = 4;
    localparam int CH_W    = 2;
`ifdef CLK_DIV_MULTI_SHADOW_EN
    localparam logic SH = 1'b1;
`else
    localparam logic SH = 1'b0;
`endif

    logic             clki = 1'b0;
    logic             rstn = 1'b0;
    logic             wr_en = 1'b0;
    logic [CH_W-1:0]  wr_ch = '0;
    logic [DIV_W-1:0] wr_div = '0;
    logic             wr_ack;
    logic [N_CH-1:0]  clk_out, tick_out, pending;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] pa_c, pa_t;
    logic [1:0] b_c [11];
    logic [1:0] b_t [11];
    logic [1:0] b_p [11];

    clk_div_multi #(
        .N_CH   (N_CH),
        .DIV_W  (DIV_W),
        .DEF_DIV(DEF_DIV)
    ) dut (
        .clki    (clki),
        .rstn    (rstn),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_div  (wr_div),
        .wr_ack  (wr_ack),
        .clk_out (clk_out),
        .tick_out(tick_out),
        .pending (pending)
    );

    always #5 clki = ~clki;

    task automatic step();
        @(posedge clki);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chn(input string tag, input int ch, input logic c, input logic t, input logic p);
        chk({tag, "_clk"}, 32'(clk_out[ch]), 32'(c));
        chk({tag, "_tick"}, 32'(tick_out[ch]), 32'(t));
        chk({tag, "_pend"}, 32'(pending[ch]), 32'(p));
    endtask

    task automatic wr_step(input int ch, input int d);
        wr_en  = 1'b1;
        wr_ch  = CH_W'(ch);
        wr_div = DIV_W'(d);
        step();
        wr_en  = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_clk"}, 32'(clk_out), 32'h7);
        chk({tag, "_tick"}, 32'(tick_out), 32'h0);
        chk({tag, "_pend"}, 32'(pending), 32'h0);
        chk({tag, "_ack"}, 32'(wr_ack), 32'h0);
    endtask

    initial begin
        pa_c = 8'b10011001;
        pa_t = 8'b10001000;
`ifdef CLK_DIV_MULTI_SHADOW_EN
        b_c = '{2'b11, 2'b00, 2'b00, 2'b11, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11, 2'b10, 2'b10};
        b_t = '{2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00};
        b_p = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
`else
        b_c = '{2'b11, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b01, 2'b00, 2'b10};
        b_t = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10};
        b_p = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
`endif
        // reset state
        step();
        step();
        chk_reset("rst");
        rstn = 1'b1;
        // default divisor 4 on every channel: high 2, low 2, tick on cnt 0
        for (int k = 0; k < 8; k++) begin
            step();
            chk($sformatf("def_clk%0d", k), 32'(clk_out), pa_c[k] ? 32'h7 : 32'h0);
            chk($sformatf("def_tick%0d", k), 32'(tick_out), pa_t[k] ? 32'h7 : 32'h0);
        end
        // ch1 -> 5, ch0 keeps running at 4
        wr_en  = 1'b1;
        wr_ch  = 2'd1;
        wr_div = 16'd5;
        for (int k = 0; k < 11; k++) begin
            step();
            wr_en = 1'b0;
            chk($sformatf("d5_clk%0d", k), 32'(clk_out[1:0]), 32'(b_c[k]));
            chk($sformatf("d5_tick%0d", k), 32'(tick_out[1:0]), 32'(b_t[k]));
            chk($sformatf("d5_pend%0d", k), 32'(pending[1:0]), 32'(b_p[k]));
            chk($sformatf("d5_ack%0d", k), 32'(wr_ack), 32'(k == 0));
        end
        // ch0 -> 8, then 3 written while registered cnt is 2
`ifdef CLK_DIV_MULTI_SHADOW_EN
        wr_step(0, 8); chn("c20", 0, 1, 1, 1); chk("c20_ack", 32'(wr_ack), 32'h1);
        step(); chn("c21", 0, 1, 0, 1);
        step(); chn("c22", 0, 0, 0, 1);
        step(); chn("c23", 0, 0, 0, 1);
        step(); chn("c24", 0, 1, 1, 0);
        step(); chn("c25", 0, 1, 0, 0);
        step(); chn("c26", 0, 1, 0, 0);
        wr_step(0, 3); chn("c27", 0, 1, 0, 1); chk("c27_ack", 32'(wr_ack), 32'h1);
        step(); chn("c28", 0, 0, 0, 1);
        step(); chn("c29", 0, 0, 0, 1);
        step(); chn("c30", 0, 0, 0, 1);
        step(); chn("c31", 0, 0, 0, 1);
        step(); chn("c32", 0, 1, 1, 0);
        step(); chn("c33", 0, 1, 0, 0);
        step(); chn("c34", 0, 0, 0, 0);
        step(); chn("c35", 0, 1, 1, 0);
`else
        wr_step(0, 8); chn("c20", 0, 1, 0, 0); chk("c20_ack", 32'(wr_ack), 32'h1);
        step(); chn("c21", 0, 1, 0, 0);
        step(); chn("c22", 0, 1, 0, 0);
        wr_step(0, 3); chn("c23", 0, 1, 0, 0); chk("c23_ack", 32'(wr_ack), 32'h1);
        step(); chn("c24", 0, 1, 0, 0);
        step(); chn("c25", 0, 0, 0, 0);
        step(); chn("c26", 0, 1, 1, 0);
        step(); chn("c27", 0, 1, 0, 0);
        step(); chn("c28", 0, 0, 0, 0);
        step(); chn("c29", 0, 1, 1, 0);
`endif
        // reset mid-period with a write outstanding
        wr_step(1, 7);
        chk("e_ack", 32'(wr_ack), 32'h1);
        chk("e_pend", 32'(pending[1]), 32'(SH));
        #2 rstn = 1'b0;
        #1 chk_reset("e_async");
        step();
        step();
        chk_reset("e_hold");
        rstn = 1'b1;
        // ch1 disabled with 0, then divisor 1
`ifdef CLK_DIV_MULTI_SHADOW_EN
        wr_step(1, 0); chn("d1", 1, 1, 0, 1); chk("d1_ack", 32'(wr_ack), 32'h1);
        step(); chn("d2", 1, 0, 0, 1);
        step(); chn("d3", 1, 0, 0, 1);
        step(); chn("d4", 1, 0, 0, 0);
        step(); chn("d5", 1, 0, 0, 0);
        step(); chn("d6", 1, 0, 0, 0);
        wr_step(1, 1); chn("d7", 1, 0, 0, 1);
        step(); chn("d8", 1, 1, 0, 0);
        step(); chn("d9", 1, 1, 1, 0);
        step(); chn("d10", 1, 1, 1, 0);
`else
        wr_step(1, 0); chn("d1", 1, 0, 0, 0); chk("d1_ack", 32'(wr_ack), 32'h1);
        chn("d1_ch0", 0, 1, 0, 0);
        step(); chn("d2", 1, 0, 0, 0);
        step(); chn("d3", 1, 0, 0, 0);
        wr_step(1, 1); chn("d4", 1, 1, 0, 0);
        step(); chn("d5", 1, 1, 1, 0);
        step(); chn("d6", 1, 1, 1, 0);
        step(); chn("d7", 1, 1, 1, 0);
`endif
        // out-of-range channel: ignored, no ack
        wr_step(3, 5);
        chk("bad_ack", 32'(wr_ack), 32'h0);
        chn("bad_ch1", 1, 1, 1, 0);
        chk("bad_pend", 32'(pending), 32'h0);
        step();
        chk("bad_ack2", 32'(wr_ack), 32'h0);
        chn("bad_ch1b", 1, 1, 1, 0);
        // back-to-back writes each acknowledged
        wr_en  = 1'b1;
        wr_ch  = 2'd0;
        wr_div = 16'd2;
        step();
        chk("b2b_ack0", 32'(wr_ack), 32'h1);
        wr_ch = 2'd2;
        step();
        chk("b2b_ack1", 32'(wr_ack), 32'h1);
        wr_en = 1'b0;
        step();
        chk("b2b_ack2", 32'(wr_ack), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
